// File: rtl/timing_leak_monitor_if.sv
// Bus between the timing-leak monitor and the block that owns the units under test.
// The slave side is the monitor; the master side drives start/done and observes results.
interface timing_leak_monitor_if #(
    parameter int NCH = 2,
    parameter int CW  = 16
);
    logic           start;
    logic [NCH-1:0] done;
    logic           busy;
    logic [NCH-1:0] done_mask;
    logic [CW-1:0]  first_lat;
    logic [CW-1:0]  last_lat;
    logic [CW-1:0]  skew;
    logic           complete;
    logic           leak;
    logic           timeout;
    logic           leak_sticky;
    logic [CW-1:0]  leak_count;

    modport slave (
        input  start, done,
        output busy, done_mask, first_lat, last_lat, skew, complete,
               leak, timeout, leak_sticky, leak_count
    );

    modport master (
        output start, done,
        input  busy, done_mask, first_lat, last_lat, skew, complete,
               leak, timeout, leak_sticky, leak_count
    );
endinterface

// File: rtl/timing_leak_monitor.sv
// Measures per-channel completion latency after a common start and flags runs whose
// channels finish at different times (a timing side channel) or never finish.
module timing_leak_monitor #(
    parameter int NCH     = 2,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  rst,
    timing_leak_monitor_if.slave bus
);
    localparam logic [CW-1:0] TIMEOUT_CW = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } stateT;

    stateT          state, stateNext;
    logic [CW-1:0]  cnt, cntNext;
    logic [NCH-1:0] doneMask, maskNext;
    logic [CW-1:0]  firstLat, firstNext;
    logic [CW-1:0]  lastLat, lastNext;
    logic [CW-1:0]  skewReg, skewNext;
    logic           leakReg, leakNext;
    logic           timeoutReg, timeoutNext;
    logic           leakSticky, stickyNext;
    logic [CW-1:0]  leakCount, countNext;
    logic           busyReg, completeReg;
    logic [NCH-1:0] newDone;
    logic [CW-1:0]  firstEff;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can hold a value (no latch).
        stateNext   = state;
        cntNext     = cnt;
        maskNext    = doneMask;
        firstNext   = firstLat;
        lastNext    = lastLat;
        skewNext    = skewReg;
        leakNext    = leakReg;
        timeoutNext = timeoutReg;
        stickyNext  = leakSticky;
        countNext   = leakCount;
        newDone     = '0;
        firstEff    = firstLat;

        case (state)
            IDLE: begin
                // done is deliberately not looked at here, even in the start cycle.
                if (bus.start) begin
                    stateNext   = RUN;
                    cntNext     = CW'(1);
                    maskNext    = '0;
                    firstNext   = '0;
                    lastNext    = '0;
                    skewNext    = '0;
                    leakNext    = 1'b0;
                    timeoutNext = 1'b0;
                end
            end

            RUN: begin
                cntNext  = cnt + 1'b1;
                newDone  = bus.done & ~doneMask;
                maskNext = doneMask | newDone;

                // firstEff lets the same cycle's first completion feed the skew subtraction.
                if ((doneMask == '0) && (newDone != '0)) begin
                    firstEff  = cnt;
                    firstNext = cnt;
                end

                if (&maskNext) begin
                    lastNext  = cnt;
                    skewNext  = cnt - firstEff;
                    leakNext  = (cnt != firstEff);
                    stateNext = REPORT;
                end else if (cnt == TIMEOUT_CW) begin
                    timeoutNext = 1'b1;
                    leakNext    = 1'b1;
                    lastNext    = TIMEOUT_CW;
                    skewNext    = (maskNext != '0) ? (TIMEOUT_CW - firstEff) : '0;
                    stateNext   = REPORT;
                end
            end

            REPORT: begin
                stateNext = IDLE;
                if (leakReg) begin
                    stickyNext = 1'b1;
                    if (leakCount != '1) begin
                        countNext = leakCount + 1'b1;
                    end
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            doneMask    <= '0;
            firstLat    <= '0;
            lastLat     <= '0;
            skewReg     <= '0;
            leakReg     <= 1'b0;
            timeoutReg  <= 1'b0;
            leakSticky  <= 1'b0;
            leakCount   <= '0;
            busyReg     <= 1'b0;
            completeReg <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            doneMask    <= maskNext;
            firstLat    <= firstNext;
            lastLat     <= lastNext;
            skewReg     <= skewNext;
            leakReg     <= leakNext;
            timeoutReg  <= timeoutNext;
            leakSticky  <= stickyNext;
            leakCount   <= countNext;
            busyReg     <= (stateNext == RUN);
            completeReg <= (stateNext == REPORT);
        end
    end

    assign bus.busy        = busyReg;
    assign bus.complete    = completeReg;
    assign bus.done_mask   = doneMask;
    assign bus.first_lat   = firstLat;
    assign bus.last_lat    = lastLat;
    assign bus.skew        = skewReg;
    assign bus.leak        = leakReg;
    assign bus.timeout     = timeoutReg;
    assign bus.leak_sticky = leakSticky;
    assign bus.leak_count  = leakCount;
endmodule
